// File: rtl/cnn_pkg.sv
// Shared CNN layer definitions: output-dimension helper, collector state encoding
// and the bfloat16 word width.
package cnn_pkg;

    localparam int BF16_W = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } collector_state_t;

    // The de-arrangement stage uses this same helper, so both sides agree on oH.
    function automatic int out_dim(input int ih, input int wh, input int p, input int s);
        return (ih - wh + 2 * p) / s + 1;
    endfunction

endpackage

// File: rtl/ofmap_collector_if.sv
// Stream-in / buffer-out bundle of the ofmap collector.
interface ofmap_collector_if #(
    parameter int K    = 4,
    parameter int NPIX = 9,
    parameter int BW   = 16
);
    // Handshake: a beat transfers on a clock edge where in_valid && in_ready. The
    // buffer is offered while out_valid is high and is released on the edge where
    // out_ready is seen high; the buffer never changes while out_valid is high.
    logic                             in_valid;
    logic                             in_ready;
    logic [K-1:0][BW-1:0]             in_data;
    logic                             in_last;
    logic [K-1:0][NPIX-1:0][BW-1:0]   ofmap_rearranged;
    logic                             out_valid;
    logic                             out_ready;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, ofmap_rearranged, out_valid
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, ofmap_rearranged, out_valid
    );

endinterface

// File: rtl/ofmap_collector.sv
// Collects one layer of PE-array output pixels (K lanes per beat) into a flattened
// ofmap buffer and holds it until the downstream stage takes it.
module ofmap_collector
    import cnn_pkg::*;
#(
    parameter int K  = 4,
    parameter int iH = 6,
    parameter int wH = 3,
    parameter int P  = 1,
    parameter int S  = 2,
    parameter int BW = BF16_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    ofmap_collector_if.slave   bus,
    output logic               frame_err,
    output collector_state_t   state_dbg
);

    localparam int OH   = out_dim(iH, wH, P, S);
    localparam int NPIX = OH * OH;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;

    collector_state_t                state;
    logic [CW-1:0]                   cnt;
    logic                            in_ready_q;
    logic                            out_valid_q;
    logic [K-1:0][NPIX-1:0][BW-1:0]  ofmap_q;

    logic accept;
    logic at_last;

    assign accept  = bus.in_valid && in_ready_q;
    assign at_last = (cnt == CW'(NPIX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            frame_err   <= 1'b0;
            ofmap_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= COLLECT;
                        cnt        <= '0;
                        in_ready_q <= 1'b1;
                        frame_err  <= 1'b0;
                    end
                end
                COLLECT: begin
                    // A restart takes priority over a beat offered in the same cycle.
                    if (start) begin
                        cnt       <= '0;
                        frame_err <= 1'b0;
                    end else if (accept) begin
                        for (int k = 0; k < K; k++) begin
                            ofmap_q[k][cnt] <= bus.in_data[k];
                        end
                        if (bus.in_last != at_last) begin
                            frame_err <= 1'b1;
                        end
                        if (at_last) begin
                            state       <= HOLD;
                            cnt         <= '0;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready         = in_ready_q;
    assign bus.out_valid        = out_valid_q;
    assign bus.ofmap_rearranged = ofmap_q;
    assign state_dbg            = state;

endmodule

// File: tb/tb_ofmap_collector.sv
// Directed, table-driven bench for ofmap_collector (defaults: oH=3, NPIX=9).
module tb_ofmap_collector;
    import cnn_pkg::*;

    localparam int K    = 4;
    localparam int OH   = out_dim(6, 3, 1, 2);
    localparam int NPIX = OH * OH;
    localparam int BW   = BF16_W;

    typedef logic [K-1:0][NPIX-1:0][BW-1:0] buf_t;

    typedef struct {
        logic             start;
        logic             valid;
        logic             last;
        logic             ordy;
        logic [BW-1:0]    base;
        logic             exp_ir;
        logic             exp_ov;
        logic             exp_err;
        collector_state_t exp_st;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             frame_err;
    collector_state_t state_dbg;

    ofmap_collector_if #(.K(K), .NPIX(NPIX), .BW(BW)) bus ();

    ofmap_collector #(.K(K), .iH(6), .wH(3), .P(1), .S(2), .BW(BW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus.slave),
        .frame_err (frame_err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[$];

    task automatic drive(input logic s, input logic v, input logic l, input logic o,
                         input logic [BW-1:0] base);
        start         = s;
        bus.in_valid  = v;
        bus.in_last   = l;
        bus.out_ready = o;
        for (int k = 0; k < K; k++) bus.in_data[k] = base + BW'(k);
    endtask

    task automatic add(input logic s, input logic v, input logic l, input logic o,
                       input logic [BW-1:0] base, input logic eir, input logic eov,
                       input logic eerr, input collector_state_t est);
        vec_t t;
        t.start = s; t.valid = v; t.last = l; t.ordy = o; t.base = base;
        t.exp_ir = eir; t.exp_ov = eov; t.exp_err = eerr; t.exp_st = est;
        vecs.push_back(t);
    endtask

    task automatic check_ctl(input string tag, input int idx, input logic eir,
                             input logic eov, input logic eerr, input collector_state_t est);
        n_vec++;
        if (bus.in_ready !== eir || bus.out_valid !== eov || frame_err !== eerr ||
            state_dbg !== est) begin
            n_miss++;
            $display("FAIL %s[%0d]: got ir=%b ov=%b err=%b st=%0d, want ir=%b ov=%b err=%b st=%0d",
                     tag, idx, bus.in_ready, bus.out_valid, frame_err, state_dbg,
                     eir, eov, eerr, est);
        end
    endtask

    // Apply every queued vector for one cycle, then compare the post-edge outputs.
    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].valid, vecs[i].last, vecs[i].ordy, vecs[i].base);
            @(posedge clk);
            #1;
            check_ctl(tag, i, vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_err, vecs[i].exp_st);
        end
        vecs.delete();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    // Expected buffer for a layer whose pixel p carried base0 + 16*p + k on lane k.
    task automatic check_buf(input string tag, input logic [BW-1:0] base0, input logic zero);
        buf_t exp_buf;
        for (int k = 0; k < K; k++)
            for (int p = 0; p < NPIX; p++)
                exp_buf[k][p] = zero ? '0 : base0 + BW'(16 * p) + BW'(k);
        n_vec++;
        if (bus.ofmap_rearranged !== exp_buf) begin
            n_miss++;
            $display("FAIL %s buffer: got %h, want %h", tag, bus.ofmap_rearranged, exp_buf);
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        check_ctl("reset", 0, 1'b0, 1'b0, 1'b0, IDLE);
        check_buf("reset", 16'h0000, 1'b1);
        rst = 1'b0;

        // Nominal layer followed by five cycles of backpressure with junk on the input.
        add(1, 0, 0, 0, 16'h0000, 1, 0, 0, COLLECT);
        for (int p = 0; p < NPIX; p++)
            add(0, 1, p == NPIX - 1, 0, 16'h3F80 + BW'(16 * p), p != NPIX - 1, p == NPIX - 1,
                0, (p == NPIX - 1) ? HOLD : COLLECT);
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 16'hDEAD, 0, 1, 0, HOLD);
        run_table("nominal");
        check_buf("nominal_hold", 16'h3F80, 1'b0);
        n_vec++;
        if (bus.ofmap_rearranged[2][5] !== 16'h3FD2) begin
            n_miss++;
            $display("FAIL entry_2_5: got %h, want 3fd2", bus.ofmap_rearranged[2][5]);
        end
        add(0, 1, 0, 1, 16'hDEAD, 0, 0, 0, IDLE);
        add(0, 1, 0, 0, 16'hDEAD, 0, 0, 0, IDLE);
        run_table("release");
        check_buf("after_release", 16'h3F80, 1'b0);

        // Bubbles: invalid cycles carry junk that must never land in the buffer.
        add(1, 0, 0, 0, 16'h0000, 1, 0, 0, COLLECT);
        for (int i = 0; i < 2 * NPIX - 1; i++) begin
            if (i % 2 == 0)
                add(0, 1, i == 2 * NPIX - 2, 0, 16'h2000 + BW'(16 * (i / 2)),
                    i != 2 * NPIX - 2, i == 2 * NPIX - 2, 0,
                    (i == 2 * NPIX - 2) ? HOLD : COLLECT);
            else
                add(0, 0, 0, 0, 16'hDEAD, 1, 0, 0, COLLECT);
        end
        run_table("bubbles");
        check_buf("bubbles", 16'h2000, 1'b0);
        add(0, 0, 0, 1, 16'h0000, 0, 0, 0, IDLE);
        run_table("bubbles_release");

        // Framing: in_last early on p=4; start in HOLD ignored; start+out_ready drops start.
        add(1, 0, 0, 0, 16'h0000, 1, 0, 0, COLLECT);
        for (int p = 0; p < NPIX; p++)
            add(0, 1, p == 4, 0, 16'h3F80 + BW'(16 * p), p != NPIX - 1, p == NPIX - 1,
                p >= 4, (p == NPIX - 1) ? HOLD : COLLECT);
        add(0, 0, 0, 0, 16'h0000, 0, 1, 1, HOLD);
        add(1, 0, 0, 0, 16'h0000, 0, 1, 1, HOLD);
        add(1, 0, 0, 1, 16'h0000, 0, 0, 1, IDLE);
        add(0, 0, 0, 0, 16'h0000, 0, 0, 1, IDLE);
        add(1, 0, 0, 0, 16'h0000, 1, 0, 0, COLLECT);
        // Restart after 4 beats; the next 9 beats fill indices 0..8 with new data.
        for (int p = 0; p < 4; p++)
            add(0, 1, 0, 0, 16'h1000 + BW'(16 * p), 1, 0, 0, COLLECT);
        add(1, 1, 0, 0, 16'hDEAD, 1, 0, 0, COLLECT);
        for (int p = 0; p < NPIX; p++)
            add(0, 1, p == NPIX - 1, 0, 16'h4000 + BW'(16 * p), p != NPIX - 1, p == NPIX - 1,
                0, (p == NPIX - 1) ? HOLD : COLLECT);
        run_table("frame_restart");
        check_buf("restart", 16'h4000, 1'b0);
        add(0, 0, 0, 1, 16'h0000, 0, 0, 0, IDLE);
        run_table("restart_release");

        // Missing in_last on the final beat also flags a framing error.
        add(1, 0, 0, 0, 16'h0000, 1, 0, 0, COLLECT);
        for (int p = 0; p < NPIX; p++)
            add(0, 1, 0, 0, 16'h3F80 + BW'(16 * p), p != NPIX - 1, p == NPIX - 1,
                p == NPIX - 1, (p == NPIX - 1) ? HOLD : COLLECT);
        add(0, 0, 0, 1, 16'h0000, 0, 0, 1, IDLE);
        run_table("missing_last");

        // Reset in the middle of a layer discards everything.
        add(1, 0, 0, 0, 16'h0000, 1, 0, 0, COLLECT);
        for (int p = 0; p < 4; p++)
            add(0, 1, 0, 0, 16'h5000 + BW'(16 * p), 1, 0, 0, COLLECT);
        run_table("pre_reset");
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h6000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_ctl("mid_reset", 0, 1'b0, 1'b0, 1'b0, IDLE);
        check_buf("mid_reset", 16'h0000, 1'b1);
        @(posedge clk);
        #1;
        check_ctl("post_reset", 0, 1'b0, 1'b0, 1'b0, IDLE);
        check_buf("post_reset", 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ofmap_collector.md
Name: ofmap_collector

Overview:
- Upstream neighbour of the ofmap de-arrangement stage. Captures the PE-array output stream, one output pixel per accepted beat, carrying all K filter results.
- Assembles the flattened ofmap buffer ofmap_rearranged[0:K-1][0:oH*oH-1] and holds it stable under a valid/ready handshake until the downstream stage consumes it.
- Checks the stream framing and tracks layer completion.

Parameters:
- K, 4: filters per CNN layer; number of lanes per beat.
- iH, 6: ifmap height/width.
- wH, 3: filter height/width.
- P, 1: zero-padding size.
- S, 2: stride.
- BW, 16: word width (bfloat16). Data is opaque; no arithmetic is done on it.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins collecting one layer.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  collector can accept a beat.
- in_data  in  K x BW  in_data[k] is the result of filter k for the current pixel.
- in_last  in  1  upstream marks the final pixel of the layer.
- ofmap_rearranged  out  K x (oH*oH) x BW  assembled buffer, registered.
- out_valid  out  1  buffer complete and stable.
- out_ready  in  1  downstream has consumed the buffer.
- frame_err  out  1  sticky framing-error flag.

Behaviour:
- Derived constants:
  - oH = (iH - wH + 2*P)/S + 1.
  - NPIX = oH*oH.
  - Pixel counter width is clog2(NPIX), minimum 1.
- Reset (rst high at a clk edge):
  - state = IDLE; counter = 0.
  - in_ready = 0, out_valid = 0, frame_err = 0.
  - ofmap_rearranged is cleared to all zeros.
  - Reset overrides everything, including a collection in progress; any partial data is discarded.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start moves to COLLECT with counter = 0.
- COLLECT:
  - in_ready = 1. A beat is accepted when in_valid && in_ready.
  - On accept, ofmap_rearranged[k][counter] <= in_data[k] for every k, then counter increments.
  - Accept at counter == NPIX-1 moves to HOLD next cycle and resets counter to 0.
  - in_last check: if in_last is set on a beat with counter != NPIX-1, or is clear on the beat with counter == NPIX-1, set frame_err. The collector still follows the counter, not in_last.
  - start while in COLLECT restarts the collection: counter = 0 and frame_err is cleared. Buffer contents are left as they are; they will be overwritten.
- HOLD:
  - out_valid = 1, in_ready = 0. The buffer is frozen; in_valid is ignored.
  - out_ready moves to IDLE next cycle, with out_valid low that cycle.
  - start in HOLD is ignored.
- Timing:
  - Output is registered; a write lands in the buffer the cycle after its accept.
  - out_valid rises the cycle after the last accept.
  - Minimum layer time is 1 (start) + NPIX + 1 cycles.
- frame_err is cleared only by rst or by start; it is otherwise sticky.
- Simultaneous start and out_ready in HOLD: out_ready wins and the block goes to IDLE; start is dropped.
- Layout: index counter maps to (counter/oH, counter%oH) in the downstream stage, so beats are delivered in row-major pixel order.

Decomposition:
- Shared package cnn_pkg:
  - function out_dim(iH, wH, P, S) returning oH;
  - collector state enum {IDLE, COLLECT, HOLD};
  - BF16_W = 16.
- The de-arrangement stage imports the same out_dim function, so oH is computed identically on both sides.
- No sub-module is needed. The pixel counter and its terminal compare stay inline.

Test Plan (defaults give oH=3, NPIX=9):
- Reset with rst high for 2 cycles -> in_ready=0, out_valid=0, frame_err=0, every buffer entry 0x0000.
- Nominal layer: start, then 9 back-to-back beats with in_data[k] = 16'h3F80 + 16*p + k and in_last on p=8 -> out_valid rises 1 cycle after beat 8; ofmap_rearranged[2][5] = 16'h3FD2; frame_err=0.
- Backpressure: hold out_ready=0 for 5 cycles, then pulse it -> buffer unchanged and in_ready=0 during HOLD, with in_valid held high at 16'hDEAD; state is IDLE the cycle after the pulse.
- Bubbles: in_valid toggled 1,0,1,0,... -> only valid beats are written; still 9 accepts to out_valid; buffer matches the nominal result.
- Framing: in_last on p=4 -> frame_err=1 and stays 1 through HOLD; out_valid is still reached after 9 beats. A later start clears frame_err.
- Mid-operation events:
  - rst after 4 beats -> IDLE, buffer all zero.
  - start after 4 beats -> counter restarts at 0; next 9 beats complete the layer with the new data at indices 0..8.
